// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised single-clock FIFO with occupancy count, threshold flags and flush
// Optional sticky overflow/underflow flags with err_clr: define FIFO_ERR_FLAGS_EN
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [CW-1:0]    count
);

  // Pointers only need to address DEPTH entries; wrap is explicit so any DEPTH works.
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             wr_acc;
  logic             rd_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Requests are qualified by the flags of the current (pre-edge) count; flush swallows both.
  assign wr_acc = !flush && wr && !full;
  assign rd_acc = !flush && rd && !empty;

  // Next-state for pointers, occupancy and the registered read port.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_acc) begin
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears everything except the storage array.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage write; a write is never visible to a read issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign count        = count_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; err_clr beats a same-cycle set, flush leaves them alone.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr && full) begin
        overflow_d = 1'b1;
      end
      if (rd && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param (DEPTH=5, WIDTH=8, AF=4, AE=1)
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic             wr;
  logic [WIDTH-1:0] wr_data;
  logic             rd;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
  logic             err_clr;
  logic             overflow;
  logic             underflow;
  bit               m_ovf;
  bit               m_unf;
`endif

  int vectors;
  int miscompares;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_q[$];

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .wr(wr),
    .wr_data(wr_data),
    .rd(rd),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
    .err_clr(err_clr),
    .overflow(overflow),
    .underflow(underflow),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every rd_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected rd_valid with rd_data=%02h, required no output", rd_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          miscompares++;
          $display("FAIL sb_data got %02h required %02h", rd_data, e);
        end
      end
    end
  end

  // Drive one cycle of stimulus and advance the reference model.
  task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit f, input bit rs);
    int sz;
    sz = mq.size();
    wr = w; wr_data = d; rd = r; flush = f; rst = rs;
`ifdef FIFO_ERR_FLAGS_EN
    if (rs || err_clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0) m_unf = 1'b1;
    end
`endif
    if (rs || f) begin
      mq.delete();
    end else begin
      if (r && sz != 0) exp_q.push_back(mq.pop_front());
      if (w && sz != DEPTH) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset;
    step(0, 8'h00, 0, 0, 1);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d required 0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b required 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b required 0", full); end
    vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_ae got %b required 1", almost_empty); end
    vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_af got %b required 0", almost_full); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b required 0", rd_valid); end
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data got %02h required 00", rd_data); end
`ifdef FIFO_ERR_FLAGS_EN
    vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b%b required 00", overflow, underflow); end
`endif
  endtask

  task automatic test_fill;
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h11 + 8'(i), 0, 0, 0);
      vectors++; if (count !== CW'(i + 1)) begin miscompares++; $display("FAIL fill_count i=%0d got %0d required %0d", i, count, i + 1); end
      vectors++; if (almost_full !== (i + 1 >= 4)) begin miscompares++; $display("FAIL fill_af i=%0d got %b required %b", i, almost_full, (i + 1 >= 4)); end
      vectors++; if (full !== (i + 1 == 5)) begin miscompares++; $display("FAIL fill_full i=%0d got %b required %b", i, full, (i + 1 == 5)); end
      vectors++; if (almost_empty !== (i + 1 <= 1) || empty !== 1'b0) begin miscompares++; $display("FAIL fill_empty_flags i=%0d got ae=%b e=%b", i, almost_empty, empty); end
    end
    step(1, 8'h66, 0, 0, 0);
    vectors++; if (count !== 3'd5 || full !== 1'b1) begin miscompares++; $display("FAIL overfill got count=%0d full=%b required 5/1", count, full); end
`ifdef FIFO_ERR_FLAGS_EN
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_set got %b required 1", overflow); end
    err_clr = 1'b1;
    step(0, 8'h00, 0, 0, 0);
    err_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL overflow_clr got %b required 0", overflow); end
`endif
  endtask

  task automatic test_drain;
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1, 0, 0);
      vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid i=%0d got %b required 1", i, rd_valid); end
      vectors++; if (rd_data !== 8'h11 + 8'(i)) begin miscompares++; $display("FAIL drain_data i=%0d got %02h required %02h", i, rd_data, 8'h11 + 8'(i)); end
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b required 1", empty); end
    step(0, 8'h00, 1, 0, 0);
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL underread_valid got %b required 0", rd_valid); end
    vectors++; if (rd_data !== 8'h15) begin miscompares++; $display("FAIL underread_hold got %02h required 15", rd_data); end
`ifdef FIFO_ERR_FLAGS_EN
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_set got %b required 1", underflow); end
    err_clr = 1'b1;
    step(0, 8'h00, 0, 0, 0);
    err_clr = 1'b0;
`endif
  endtask

  task automatic test_wrap;
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h01, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      step(1, 8'(i + 2), 1, 0, 0);
      vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL wrap_count i=%0d got %0d required 2", i, count); end
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin miscompares++; $display("FAIL wrap_data i=%0d got v=%b %02h required 1 %02h", i, rd_valid, rd_data, 8'(i)); end
    end
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    vectors++; if (rd_data !== 8'd51 || empty !== 1'b1) begin miscompares++; $display("FAIL wrap_tail got %02h empty=%b required 33 1", rd_data, empty); end
  endtask

  task automatic test_simul_boundary;
    for (int i = 0; i < 5; i++) step(1, 8'h21 + 8'(i), 0, 0, 0);
    step(1, 8'h77, 1, 0, 0);
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL simfull_count got %0d required 4", count); end
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h21) begin miscompares++; $display("FAIL simfull_data got v=%b %02h required 1 21", rd_valid, rd_data); end
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1, 0, 0);
      vectors++; if (rd_data !== 8'h22 + 8'(i)) begin miscompares++; $display("FAIL simfull_rest i=%0d got %02h required %02h", i, rd_data, 8'h22 + 8'(i)); end
    end
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b1;
    step(0, 8'h00, 0, 0, 0);
    err_clr = 1'b0;
`endif
    step(1, 8'h88, 1, 0, 0);
    vectors++; if (count !== 3'd1 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL simempty got count=%0d v=%b required 1 0", count, rd_valid); end
`ifdef FIFO_ERR_FLAGS_EN
    vectors++; if (underflow !== 1'b1 || overflow !== 1'b0) begin miscompares++; $display("FAIL simempty_err got ov=%b un=%b required 0 1", overflow, underflow); end
`endif
    step(0, 8'h00, 1, 0, 0);
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h88) begin miscompares++; $display("FAIL simempty_next got v=%b %02h required 1 88", rd_valid, rd_data); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) step(1, 8'h31 + 8'(i), 0, 0, 0);
    step(1, 8'h99, 0, 1, 0);
    vectors++; if (count !== 3'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL flush_count got %0d empty=%b required 0 1", count, empty); end
    vectors++; if (rd_valid !== 1'b0 || rd_data !== 8'h88) begin miscompares++; $display("FAIL flush_rd got v=%b %02h required 0 88", rd_valid, rd_data); end
    step(1, 8'hA5, 0, 0, 0);
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL flush_after_wr got %0d required 1", count); end
    step(0, 8'h00, 1, 0, 0);
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin miscompares++; $display("FAIL flush_readback got v=%b %02h required 1 a5", rd_valid, rd_data); end
  endtask

  task automatic test_reset_midstream;
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'h41 + 8'(i), 0, 0, 0);
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL mid_precount got %0d required 4", count); end
    step(0, 8'h00, 1, 0, 1);
    vectors++; if (count !== 3'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL mid_count got %0d empty=%b required 0 1", count, empty); end
    vectors++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin miscompares++; $display("FAIL mid_rd got v=%b %02h required 0 00", rd_valid, rd_data); end
`ifdef FIFO_ERR_FLAGS_EN
    vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL mid_err got %b%b required 00", overflow, underflow); end
`endif
    step(1, 8'h5A, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin miscompares++; $display("FAIL mid_after got v=%b %02h required 1 5a", rd_valid, rd_data); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; wr_data = '0;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul_boundary();
    test_flush();
    test_reset_midstream();
    step(0, 8'h00, 0, 0, 0);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drained got %0d words outstanding required 0", exp_q.size());
    end
`ifdef FIFO_ERR_FLAGS_EN
    vectors++;
    if (overflow !== m_ovf || underflow !== m_unf) begin
      miscompares++;
      $display("FAIL err_model got %b%b required %b%b", overflow, underflow, m_ovf, m_unf);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
